// File: rtl/mm_result_drain_ctrl_if.sv
// CCI-P c1Tx-style write request channel between the result drain controller
// and the host write path; wr_alm_full flows back as the only flow control.
interface mm_result_drain_ctrl_if #(
  parameter int ADDR_W = 42
);
  logic              wr_alm_full;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [511:0]      wr_data;

  modport master (input wr_alm_full, output wr_valid, output wr_addr, output wr_data);
  modport slave  (output wr_alm_full, input wr_valid, input wr_addr, input wr_data);
endinterface

// File: rtl/mm_result_drain_ctrl.sv
// Sequences one Multi_top matrix-multiply job, drains the z result RAM into
// 512-bit lines for host write-back, then writes a status/flag line.
module mm_result_drain_ctrl #(
  parameter int Z_DEPTH        = 64,
  parameter int WORDS_PER_LINE = 16,
  parameter int ADDR_W         = 42,
  parameter int TIMEOUT        = 65535,
  localparam int ZA_W          = $clog2(Z_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   mm_start,
  input  logic                   mm_done,
  output logic [ZA_W-1:0]        z_rd_addr,
  input  logic [31:0]            z_dout,
  mm_result_drain_ctrl_if.master wr,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int NUM_LINES = Z_DEPTH / WORDS_PER_LINE;
  localparam int LINE_W    = $clog2(NUM_LINES + 1);
  localparam int RC_W      = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FLAG   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic                mm_start_r, mm_start_s;
  logic                wr_valid_r, wr_valid_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
  logic [511:0]        wr_data_r, wr_data_s;
  logic                busy_r, busy_s;
  logic                timeout_err_r, timeout_err_s;
  logic [ZA_W-1:0]     z_rd_addr_r, z_rd_addr_s;
  logic [15:0]         wdog_r, wdog_s, wdog_inc_s;
  logic [RC_W-1:0]     rd_cnt_r, rd_cnt_s;
  logic [LINE_W-1:0]   line_idx_r, line_idx_s;
  logic [ADDR_W-1:0]   base_r, base_s;

  // Flag line layout: [63:0] completion kind, [95:64] lines written, [127:96] watchdog.
  function automatic logic [511:0] flag_line(input logic [63:0] kind,
                                             input logic [31:0] lines,
                                             input logic [15:0] wdog);
    flag_line = {384'd0, 16'd0, wdog, lines, kind};
  endfunction

  // Next-state and next-output computation for the job sequencer.
  always_comb begin
    state_s       = state_r;
    mm_start_s    = 1'b0;
    wr_valid_s    = 1'b0;
    wr_addr_s     = wr_addr_r;
    wr_data_s     = wr_data_r;
    busy_s        = busy_r;
    timeout_err_s = timeout_err_r;
    z_rd_addr_s   = z_rd_addr_r;
    wdog_s        = wdog_r;
    rd_cnt_s      = rd_cnt_r;
    line_idx_s    = line_idx_r;
    base_s        = base_r;
    wdog_inc_s    = wdog_r + 16'd1;

    case (state_r)
      ST_IDLE: begin
        if (go) begin
          base_s        = base_addr;
          timeout_err_s = 1'b0;
          busy_s        = 1'b1;
          mm_start_s    = 1'b1;
          state_s       = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        wdog_s  = 16'd0;
        state_s = ST_WAIT;
      end

      ST_WAIT: begin
        wdog_s = wdog_inc_s;
        // A done arriving on the expiry cycle still takes the normal path.
        if (mm_done) begin
          line_idx_s  = {LINE_W{1'b0}};
          rd_cnt_s    = {RC_W{1'b0}};
          z_rd_addr_s = {ZA_W{1'b0}};
          state_s     = ST_READ;
        end else if (wdog_inc_s == 16'(TIMEOUT)) begin
          timeout_err_s = 1'b1;
          wr_data_s     = flag_line(64'd2, 32'd0, wdog_inc_s);
          state_s       = ST_FLAG;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_READ: begin
        // RAM data lags the address by one cycle, so word k lands while rd_cnt is k+1.
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
          wr_data_s[32*k +: 32] = (rd_cnt_r == RC_W'(k + 1)) ? z_dout : wr_data_r[32*k +: 32];
        end
        if (rd_cnt_r < RC_W'(WORDS_PER_LINE - 1)) begin
          z_rd_addr_s = z_rd_addr_r + ZA_W'(1);
        end else begin
          z_rd_addr_s = z_rd_addr_r;
        end
        if (rd_cnt_r == RC_W'(WORDS_PER_LINE)) begin
          rd_cnt_s = {RC_W{1'b0}};
          state_s  = ST_WRITE;
        end else begin
          rd_cnt_s = rd_cnt_r + RC_W'(1);
          state_s  = ST_READ;
        end
      end

      ST_WRITE: begin
        if (wr_valid_r) begin
          line_idx_s = line_idx_r + LINE_W'(1);
          if (line_idx_r == LINE_W'(NUM_LINES - 1)) begin
            wr_data_s = flag_line(64'd1, 32'(line_idx_s), wdog_r);
            state_s   = ST_FLAG;
          end else begin
            z_rd_addr_s = z_rd_addr_r + ZA_W'(1);
            rd_cnt_s    = {RC_W{1'b0}};
            state_s     = ST_READ;
          end
        end else if (!wr.wr_alm_full) begin
          wr_valid_s = 1'b1;
          wr_addr_s  = base_r + ADDR_W'(1) + ADDR_W'(line_idx_r);
        end else begin
          wr_valid_s = 1'b0;
        end
      end

      ST_FLAG: begin
        if (wr_valid_r) begin
          state_s = ST_FINISH;
        end else if (!wr.wr_alm_full) begin
          wr_valid_s = 1'b1;
          wr_addr_s  = base_r;
        end else begin
          wr_valid_s = 1'b0;
        end
      end

      ST_FINISH: begin
        busy_s      = 1'b0;
        z_rd_addr_s = {ZA_W{1'b0}};
        state_s     = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      mm_start_r    <= 1'b0;
      wr_valid_r    <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= 512'd0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      z_rd_addr_r   <= {ZA_W{1'b0}};
      wdog_r        <= 16'd0;
      rd_cnt_r      <= {RC_W{1'b0}};
      line_idx_r    <= {LINE_W{1'b0}};
      base_r        <= {ADDR_W{1'b0}};
    end else begin
      state_r       <= state_s;
      mm_start_r    <= mm_start_s;
      wr_valid_r    <= wr_valid_s;
      wr_addr_r     <= wr_addr_s;
      wr_data_r     <= wr_data_s;
      busy_r        <= busy_s;
      timeout_err_r <= timeout_err_s;
      z_rd_addr_r   <= z_rd_addr_s;
      wdog_r        <= wdog_s;
      rd_cnt_r      <= rd_cnt_s;
      line_idx_r    <= line_idx_s;
      base_r        <= base_s;
    end
  end

  assign mm_start    = mm_start_r;
  assign wr.wr_valid = wr_valid_r;
  assign wr.wr_addr  = wr_addr_r;
  assign wr.wr_data  = wr_data_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign z_rd_addr   = z_rd_addr_r;

endmodule

// File: tb/tb_mm_result_drain_ctrl.sv
// Randomized self-checking bench for mm_result_drain_ctrl; expected host writes
// come from a job-level model (done delay, z contents, base address).
module tb_mm_result_drain_ctrl;

  localparam int AW = 42;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          go;
  logic [AW-1:0] base_addr;
  logic          mm_start;
  logic          mm_done;
  logic [5:0]    z_rd_addr;
  logic [31:0]   z_dout;
  logic          busy;
  logic          timeout_err;

  mm_result_drain_ctrl_if #(.ADDR_W(AW)) wr_if ();

  mm_result_drain_ctrl #(
    .Z_DEPTH(64), .WORDS_PER_LINE(16), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .base_addr(base_addr),
    .mm_start(mm_start), .mm_done(mm_done), .z_rd_addr(z_rd_addr),
    .z_dout(z_dout), .wr(wr_if.master), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [31:0] zmem [64];
  always @(posedge clk) z_dout <= zmem[z_rd_addr];

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_start;
  bit            prev_valid;
  logic [AW-1:0] obs_addr[$];
  logic [511:0]  obs_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [511:0]  exp_data[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample just after the edge and log host writes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mm_start) n_start++;
    if (wr_if.wr_valid) begin
      chk("no_back_to_back_valid", 512'(prev_valid), 512'd0);
      obs_addr.push_back(wr_if.wr_addr);
      obs_data.push_back(wr_if.wr_data);
    end
    prev_valid = wr_if.wr_valid;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mm_start"},    512'(mm_start),       512'd0);
    chk({tag, "_wr_valid"},    512'(wr_if.wr_valid), 512'd0);
    chk({tag, "_busy"},        512'(busy),           512'd0);
    chk({tag, "_timeout_err"}, 512'(timeout_err),    512'd0);
    chk({tag, "_z_rd_addr"},   512'(z_rd_addr),      512'd0);
    chk({tag, "_wr_addr"},     512'(wr_if.wr_addr),  512'd0);
    chk({tag, "_wr_data"},     wr_if.wr_data,        512'd0);
  endtask

  function automatic logic [511:0] flag_model(input int kind, input int lines, input int wd);
    logic [511:0] v;
    v = 512'd0;
    v[63:0]   = 64'(kind);
    v[95:64]  = 32'(lines);
    v[127:96] = 32'(wd);
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'({$urandom(), $urandom()});
  endfunction

  // Runs one job: done pulses d cycles after the mm_start cycle (0 = never).
  task automatic run_job(input logic [AW-1:0] base, input int d, input bit stall, input bit extra_go);
    int           j;
    int           age;
    bit           normal, s2, sf, bad_v, bad_d, mid_go;
    logic [511:0] line;
    logic [511:0] ref_d;

    normal = (d != 0) && (d <= TO);
    exp_addr.delete();
    exp_data.delete();
    if (normal) begin
      for (int n = 0; n < 4; n++) begin
        line = 512'd0;
        for (int k = 0; k < 16; k++) line[32*k +: 32] = zmem[16*n + k];
        exp_addr.push_back(base + AW'(1 + n));
        exp_data.push_back(line);
      end
      exp_addr.push_back(base);
      exp_data.push_back(flag_model(1, 4, d));
    end else begin
      exp_addr.push_back(base);
      exp_data.push_back(flag_model(2, 0, TO));
    end

    obs_addr.delete();
    obs_data.delete();
    n_start = 0;
    s2 = 1'b0; sf = 1'b0; bad_v = 1'b0; bad_d = 1'b0; mid_go = 1'b0; age = 0;
    ref_d = 512'd0;

    base_addr = base;
    go = 1'b1;
    tick();
    go = 1'b0;
    base_addr = rand_addr();
    chk("busy_after_go", 512'(busy), 512'd1);
    chk("timeout_err_cleared_by_go", 512'(timeout_err), 512'd0);

    j = 0;
    while (busy && j < 2000) begin
      mm_done = (d != 0) && (j == d);
      go = 1'b0;
      if (extra_go && j == 10) go = 1'b1;
      if (extra_go && !mid_go && z_rd_addr == 6'd20) begin
        go = 1'b1;
        mid_go = 1'b1;
      end
      tick();
      j++;
      if (wr_if.wr_alm_full) begin
        age++;
        if (wr_if.wr_valid) bad_v = 1'b1;
        if (age == 2) ref_d = wr_if.wr_data;
        else if (age > 2 && wr_if.wr_data !== ref_d) bad_d = 1'b1;
        if (age == 20) begin
          wr_if.wr_alm_full = 1'b0;
          chk("stall_no_valid", 512'(bad_v), 512'd0);
          chk("stall_data_stable", 512'(bad_d), 512'd0);
        end
      end else if (stall && !s2 && z_rd_addr == 6'd47) begin
        s2 = 1'b1; wr_if.wr_alm_full = 1'b1; age = 0; bad_v = 1'b0; bad_d = 1'b0;
      end else if (stall && !sf && obs_addr.size() == 4) begin
        sf = 1'b1; wr_if.wr_alm_full = 1'b1; age = 0; bad_v = 1'b0; bad_d = 1'b0;
      end
    end
    mm_done = 1'b0;
    go = 1'b0;
    wr_if.wr_alm_full = 1'b0;

    chk("job_completes_in_budget", 512'(j < 2000), 512'd1);
    chk("mm_start_pulses", 512'(n_start), 512'd1);
    chk("timeout_err_after_job", 512'(timeout_err), 512'(!normal));
    chk("write_count", 512'(obs_addr.size()), 512'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), 512'(obs_addr[i]), 512'(exp_addr[i]));
      chk($sformatf("wr_data[%0d]", i), obs_data[i], exp_data[i]);
    end
  endtask

  initial begin
    int d;
    reset_n = 1'b0;
    go = 1'b0;
    mm_done = 1'b0;
    base_addr = '0;
    wr_if.wr_alm_full = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 64; i++) zmem[i] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Directed normal job with the counting z pattern.
    run_job(42'h1000, 50, 1'b0, 1'b0);

    // Backpressure at line 2 and at the flag line.
    for (int i = 0; i < 64; i++) zmem[i] = $urandom();
    run_job(42'h2000, 20, 1'b1, 1'b0);

    // Watchdog expiry, then a normal job must clear the sticky error.
    run_job(rand_addr(), 0, 1'b0, 1'b0);
    run_job(rand_addr(), 30, 1'b0, 1'b0);

    // go pulses while busy are ignored.
    run_job(rand_addr(), 40, 1'b0, 1'b1);

    // Asynchronous reset while a data write is stalled.
    go = 1'b1;
    base_addr = 42'h5000;
    tick();
    go = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    d = 0;
    while (d < 500 && z_rd_addr != 6'd31) begin
      mm_done = (d == 5);
      tick();
      d++;
    end
    mm_done = 1'b0;
    wr_if.wr_alm_full = 1'b1;
    repeat (6) tick();
    chk("writes_before_reset", 512'(obs_addr.size()), 512'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    repeat (3) tick();
    reset_n = 1'b1;
    wr_if.wr_alm_full = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    repeat (30) tick();
    chk("no_write_after_reset", 512'(obs_addr.size()), 512'd0);
    chk("idle_after_reset", 512'(busy), 512'd0);

    // done on the exact expiry cycle, then one cycle later.
    run_job(rand_addr(), TO, 1'b0, 1'b0);
    run_job(rand_addr(), TO + 1, 1'b0, 1'b0);

    // Address wrap at the top of the line address space.
    run_job(42'h3FF_FFFF_FFFE, 7, 1'b1, 1'b0);

    // Randomized jobs.
    repeat (8) begin
      for (int i = 0; i < 64; i++) zmem[i] = $urandom();
      d = int'($urandom_range(1, 110));
      run_job(rand_addr(), d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
